hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline. It drives hold and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard classes:
  - load-use data hazards (ID vs EX);
  - taken-branch control hazards resolved in EX;
  - multi-cycle data-memory waits in MEM.
- A small FSM tracks memory waits, with a timeout watchdog that latches a fatal error.

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and dmem-wait hazards.
// Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit performance counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_id,
    input  logic [4:0]  id_rs2_id,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_valid,
    input  logic        mem_req,
    input  logic        dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_load_use,
`endif
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_wb_flush,
    output logic        mem_timeout
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_block, br_flush, load_use;
    logic             err_act, blk_act, br_act, lu_act;

    assign mem_block = mem_valid & mem_req & ~dmem_ready;
    assign br_flush  = ex_valid & ex_branch_taken;
    // x0 is never a real producer, so it cannot create a dependency.
    assign load_use  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                       ((ex_rd == id_rs1_id) | (ex_rd == id_rs2_id));

    // Priority decode: error > memory block > branch > load-use.
    assign err_act = (state == ERROR);
    assign blk_act = ~err_act & mem_block;
    assign br_act  = ~err_act & ~mem_block & br_flush;
    assign lu_act  = ~err_act & ~mem_block & ~br_flush & load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_block) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        mem_timeout  = 1'b0;
        if (!rst_n) begin
            mem_timeout = 1'b0;
        end else if (err_act) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_timeout  = 1'b1;
        end else if (blk_act) begin
            // Freeze everything up to MEM; a branch in EX re-presents once unblocked.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (br_act) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_act) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_load_use     <= '0;
        end else begin
            if ((blk_act | lu_act) && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (br_act && perf_flushes != '1)
                perf_flushes <= perf_flushes + 32'd1;
            if (lu_act && perf_load_use != '1)
                perf_load_use <= perf_load_use + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; outputs packed as
// {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, mem_timeout}.
module tb_hazard_ctrl;
    localparam int TMO = 4;

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_BR   = 8'b0010_1000;
    localparam logic [7:0] O_BLK  = 8'b1101_0110;
    localparam logic [7:0] O_ERR  = 8'b1101_0101;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       id_valid, ex_valid, ex_mem_read, ex_branch_taken;
    logic       mem_valid, mem_req, dmem_ready;
    logic [4:0] id_rs1_id, id_rs2_id, ex_rd;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, mem_wb_flush, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flushes, perf_load_use;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_valid(mem_valid), .mem_req(mem_req), .dmem_ready(dmem_ready),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
        .perf_load_use(perf_load_use),
`endif
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
        .mem_timeout(mem_timeout)
    );

    typedef struct {
        logic       idv;
        logic [4:0] rs1, rs2;
        logic       exv, ld;
        logic [4:0] rd;
        logic       br, mv, mr, rdy;
        logic [7:0] exp;
        string      name;
    } vec_t;

    function automatic vec_t mk(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic exv, input logic ld, input logic [4:0] rd,
                                input logic br, input logic mv, input logic mr, input logic rdy,
                                input logic [7:0] exp, input string name);
        vec_t v;
        v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.exv = exv; v.ld = ld; v.rd = rd;
        v.br = br; v.mv = mv; v.mr = mr; v.rdy = rdy; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        id_valid = v.idv; id_rs1_id = v.rs1; id_rs2_id = v.rs2;
        ex_valid = v.exv; ex_mem_read = v.ld; ex_rd = v.rd; ex_branch_taken = v.br;
        mem_valid = v.mv; mem_req = v.mr; dmem_ready = v.rdy;
    endtask

    task automatic chk(input logic [7:0] exp, input string name);
        logic [7:0] act;
        act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mem_timeout};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input logic [31:0] act, input logic [31:0] exp, input string name);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector shortly after the rising edge, check mid-cycle, then advance.
    task automatic cyc(input vec_t v);
        set_in(v);
        #3;
        chk(v.exp, v.name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[13];
    vec_t idle, blk, blk_br, rdy_br, lu;

    initial begin
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "idle");
        blk    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_BLK,  "mem_wait");
        blk_br = mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 0, O_BLK,  "br_held_in_wait");
        rdy_br = mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 1, O_BR,   "br_after_wait");
        lu     = mk(1, 0, 5, 1, 1, 5, 0, 0, 0, 0, O_LU,   "load_use_after");

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "idle");
        tbl[1]  = mk(1, 3, 5, 1, 1, 5, 0, 0, 0, 0, O_LU,   "lu_rs2");
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "lu_one_bubble");
        tbl[3]  = mk(1, 9, 4, 1, 1, 9, 0, 0, 0, 0, O_LU,   "lu_rs1");
        tbl[4]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, O_NONE, "lu_x0");
        tbl[5]  = mk(0, 3, 5, 1, 1, 5, 0, 0, 0, 0, O_NONE, "lu_id_invalid");
        tbl[6]  = mk(1, 3, 5, 1, 0, 5, 0, 0, 0, 0, O_NONE, "no_load");
        tbl[7]  = mk(1, 3, 5, 0, 1, 5, 0, 0, 0, 0, O_NONE, "ex_invalid");
        tbl[8]  = mk(1, 5, 7, 1, 1, 6, 0, 0, 0, 0, O_NONE, "no_match");
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, O_BR,   "branch");
        tbl[10] = mk(1, 3, 5, 1, 1, 5, 1, 0, 0, 0, O_BR,   "branch_over_lu");
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_NONE, "branch_ex_invalid");
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_NONE, "mem_ready_first");

        // Outputs must stay low under reset even with a live load-use on the inputs.
        set_in(mk(1, 3, 5, 1, 1, 5, 1, 1, 1, 0, O_NONE, "in_reset"));
        #2;
        chk(O_NONE, "in_reset");
        do_reset();

        foreach (tbl[i]) cyc(tbl[i]);

        // Two back-to-back 3-cycle waits; a second wait must not accumulate toward the timeout.
        repeat (2) begin
            repeat (3) cyc(blk);
            cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_NONE, "wait_done"));
            cyc(idle);
        end
        cyc(lu);

        // Branch held through a 2-cycle wait, flushes when dmem completes.
        repeat (2) cyc(blk_br);
        cyc(rdy_br);
        cyc(idle);

        // Watchdog: 4 blocked cycles, then sticky error.
        repeat (TMO) cyc(blk);
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_ERR, "timeout"));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_ERR, "timeout_held"));
        cyc(mk(1, 3, 5, 1, 1, 5, 1, 1, 1, 1, O_ERR, "timeout_sticky"));
        set_in(idle);
        #2;
        rst_n = 1'b0;
        #1;
        chk(O_NONE, "async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(idle);
        cyc(mk(1, 3, 5, 1, 1, 5, 0, 0, 0, 0, O_LU, "lu_after_reset"));

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        cyc(idle);
        cyc(lu);
        cyc(idle);
        cyc(lu);
        cyc(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, O_BR, "perf_branch"));
        repeat (3) cyc(blk);
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_NONE, "perf_wait_done"));
        cyc(idle);
        chk32(perf_load_use, 32'd2, "perf_load_use");
        chk32(perf_flushes, 32'd1, "perf_flushes");
        chk32(perf_stall_cycles, 32'd5, "perf_stall_cycles");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
